morse_seq_control: RTL and testbench
====================================

# morse_seq_control

Command sequencer and two-way arbiter for the Morse pattern emitter. Two requesters each present a message of up to 8 symbols. The block grants one requester round-robin, latches its message and repeat count, and drives the emitter's `func_en_sig` / `cmd_start_sig` / `cmd_done_sig` handshake one symbol at a time. It pulses a per-requester done flag when the message finishes. It replaces the fixed demo control path in front of `sos_module`.

## Interface
- `MAX_SYM`, 8: symbols per message. Message width is 2*MAX_SYM; length field is 4 bits.
- `CLK`  in  1  system clock; all state on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `req_sig`  in  2  level request per requester; bit0 = requester 0.
- `msg0_data`, `msg1_data`  in  16  symbols, LSB-first; symbol i = bits [2i+1:2i].
- `msg0_len`, `msg1_len`  in  4  symbol count, 0..15; values >8 clamp to 8.
- `rpt_num`  in  4  repeat count, sampled at grant; 0 is treated as 1.
- `gnt_sig`  out  2  one-hot grant, held for the whole job.
- `done_sig`  out  2  one-cycle completion pulse per requester.
- `busy_sig`  out  1  high from grant until completion.
- `func_en_sig`  out  1  emitter enable; equals `busy_sig`.
- `cmd_start_sig`  out  4  one-hot emitter command.
- `cmd_done_sig`  in  1  emitter command-complete pulse.

## Operation
- Symbol encoding:
  - 00 = dot → cmd 4'b0001
  - 01 = dash → cmd 4'b0010
  - 10 = letter gap → cmd 4'b0100
  - 11 = word gap → cmd 4'b1000
- Reset values: all outputs 0, FSM in IDLE, round-robin pointer favours requester 0, symbol index and repeat counter 0.
- FSM states: IDLE → LOAD → ISSUE → WAIT → (CLEAR → ISSUE | RGAP → WAIT | FINISH) → IDLE.
- IDLE:
  - If any `req_sig` bit is high, grant one.
  - Single request: grant it.
  - Both requests: grant the requester not served last.
  - Go to LOAD.
- LOAD:
  - Latch the granted message data, clamped length and rpt_num (0→1).
  - Reset symbol index and repeat counter.
  - Length 0 → FINISH; otherwise → ISSUE.
- ISSUE: drive `cmd_start_sig` from the current symbol; → WAIT.
- WAIT:
  - Hold `cmd_start_sig` until `cmd_done_sig` = 1, then clear it.
  - Not the last symbol: index+1, → CLEAR.
  - Last symbol and repeats remain: index=0, repeat+1, → RGAP.
  - Last symbol of last repeat: → FINISH.
- CLEAR: one idle cycle with `cmd_start_sig` = 0; → ISSUE.
- RGAP: issue the automatic word gap (4'b1000) between repeats, wait for `cmd_done_sig`, then → CLEAR.
- FINISH:
  - Pulse `done_sig[granted]`.
  - Drop `gnt_sig`, `busy_sig` and `func_en_sig`.
  - Record the served requester in the pointer; → IDLE.
- Message data, length and repeat count are latched, so later changes to `msg*` and `rpt_num`, or `req_sig` dropping mid-job, do not affect the running job.
- `cmd_done_sig` outside WAIT/RGAP is ignored.
- `RST` mid-job: all outputs go to 0 immediately. No done pulse is issued and the job is discarded.

## Timing
- All outputs are registered.
- `req_sig` high, sampled at edge T in IDLE → `gnt_sig`, `busy_sig`, `func_en_sig` high after T+1.
- First `cmd_start_sig` high after T+2; message latched at T+1.
- `cmd_done_sig` sampled at edge D → `cmd_start_sig` low after D+1.
- Next command high after D+2, i.e. exactly one zero cycle between commands.
- Final `cmd_done_sig` at D → `done_sig` high during cycle D+1 only; grant and busy drop after D+2.
- Earliest next grant after D+3.
- Length-0 job: grant at T+1, done pulse at T+2, no command issued.
- `cmd_start_sig` never has more than one bit set.

## Structure
- Package `morse_seq_pkg`:
  - symbol codes and command one-hot constants;
  - symbol→command function;
  - state enum;
  - `MAX_SYM` and the length clamp constant.
- Sub-module `rr_arbiter_2`: 2-request round-robin with a last-served pointer, an update strobe from FINISH, and one-hot grant output.
- The top holds the FSM, message latch, index counter and repeat counter.

## Test plan
- Requester 0, msg0_data=16'h0000, len=3, rpt=1; emitter done 5 cycles after each start → three 4'b0001 commands, each separated by one zero cycle, then `done_sig`=2'b01 for one cycle.
- Requester 1, data=16'h00E4 (dot, dash, lgap, wgap), len=4, rpt=2 → commands 0001, 0010, 0100, 1000, then auto 1000, then the same four again; one `done_sig[1]` pulse.
- Both requests held continuously, len=1 each → grants alternate 01, 10, 01, 10; after reset the first grant is 01.
- len=0 → grant for one job, done pulse 1 cycle later, `cmd_start_sig` stays 0. len=12 → exactly 8 commands.
- `RST` asserted while in WAIT → all outputs 0 on the same cycle, no done pulse. After release, a new request is granted normally.
- `cmd_done_sig` pulsed in IDLE, plus msg0_data changed mid-job → no command emitted in IDLE, and the commands follow the latched data.

Source files
------------

// File: rtl/morse_seq_pkg.sv
// -----------------------------------------------------------------------------
// morse_seq_pkg
// Shared definitions for the Morse command sequencer:
//   - message geometry (MAX_SYM symbols, length clamp value)
//   - 2-bit symbol codes and the one-hot emitter command words
//   - symToCmd(): maps a symbol code onto its emitter command
//   - state_e: sequencer FSM states
// -----------------------------------------------------------------------------
package morse_seq_pkg;

  localparam int         MAX_SYM   = 8;
  localparam logic [3:0] LEN_CLAMP = 4'(MAX_SYM);

  localparam logic [1:0] SYM_DOT  = 2'b00;
  localparam logic [1:0] SYM_DASH = 2'b01;
  localparam logic [1:0] SYM_LGAP = 2'b10;
  localparam logic [1:0] SYM_WGAP = 2'b11;

  localparam logic [3:0] CMD_NONE = 4'b0000;
  localparam logic [3:0] CMD_DOT  = 4'b0001;
  localparam logic [3:0] CMD_DASH = 4'b0010;
  localparam logic [3:0] CMD_LGAP = 4'b0100;
  localparam logic [3:0] CMD_WGAP = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_CLEAR,
    ST_RGAP,
    ST_FINISH
  } state_e;

  // Every 2-bit code has a command, so the result is always one-hot.
  function automatic logic [3:0] symToCmd(input logic [1:0] sym);
    logic [3:0] cmd;
    case (sym)
      SYM_DOT:  cmd = CMD_DOT;
      SYM_DASH: cmd = CMD_DASH;
      SYM_LGAP: cmd = CMD_LGAP;
      default:  cmd = CMD_WGAP;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// -----------------------------------------------------------------------------
// rr_arbiter_2
// Two-request round-robin arbiter with a last-served pointer.
//   clk_i, rst_i : clock, async active-high reset
//   req_i        : request bits, bit0 = requester 0
//   upd_i        : strobe recording updSel_i as the last served requester
//   updSel_i     : index of the requester just served
//   gnt_o        : combinational one-hot grant (00 when nothing requests)
// -----------------------------------------------------------------------------
module rr_arbiter_2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       updSel_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  // Pointer register: resetting to "last served = 1" makes requester 0
  // the favoured one after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  // The pointer only moves when the sequencer finishes a job; on a
  // simultaneous request the requester not served last wins.
  always_comb begin
    last_d = last_q;
    if (upd_i) begin
      last_d = updSel_i;
    end

    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/morse_seq_control.sv
// -----------------------------------------------------------------------------
// morse_seq_control
// Arbitrates two message requesters, latches the winner's message and repeat
// count, and walks the emitter handshake one symbol at a time.
//   CLK, RST               : clock, async active-high reset
//   req_sig[1:0]           : level requests, bit0 = requester 0
//   msg0_data, msg1_data   : 8 symbols, LSB-first, 2 bits each
//   msg0_len, msg1_len     : symbol count, clamped to 8
//   rpt_num                : repeat count sampled at load, 0 acts as 1
//   gnt_sig[1:0]           : one-hot grant held for the job
//   done_sig[1:0]          : one-cycle completion pulse for the served requester
//   busy_sig, func_en_sig  : high from grant until completion
//   cmd_start_sig[3:0]     : one-hot emitter command
//   cmd_done_sig           : emitter command-complete pulse
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module morse_seq_control
  import morse_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  req_sig,
  input  logic [15:0] msg0_data,
  input  logic [15:0] msg1_data,
  input  logic [3:0]  msg0_len,
  input  logic [3:0]  msg1_len,
  input  logic [3:0]  rpt_num,
  output logic [1:0]  gnt_sig,
  output logic [1:0]  done_sig,
  output logic        busy_sig,
  output logic        func_en_sig,
  output logic [3:0]  cmd_start_sig,
  input  logic        cmd_done_sig
);

  state_e      state_q, state_d;
  logic        sel_q, sel_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  rptTot_q, rptTot_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  rptCnt_q, rptCnt_d;
  logic [1:0]  step_q, step_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  done_q, done_d;
  logic        busy_q, busy_d;
  logic [3:0]  cmd_q, cmd_d;

  logic [1:0]  arbGnt;
  logic        arbUpd;
  logic [3:0]  loadLenRaw;
  logic [3:0]  loadLen;
  logic [1:0]  curSym;
  logic        lastSym;
  logic        lastRpt;

  rr_arbiter_2 u_arb (
    .clk_i    (CLK),
    .rst_i    (RST),
    .req_i    (req_sig),
    .upd_i    (arbUpd),
    .updSel_i (sel_q),
    .gnt_o    (arbGnt)
  );

  assign loadLenRaw = sel_q ? msg1_len : msg0_len;
  assign loadLen    = (loadLenRaw > LEN_CLAMP) ? LEN_CLAMP : loadLenRaw;
  assign curSym     = data_q[{idx_q, 1'b0} +: 2];
  assign lastSym    = ({1'b0, idx_q} == (len_q - 4'd1));
  assign lastRpt    = (rptCnt_q == (rptTot_q - 4'd1));

  // State and output registers. Reset clears everything at once, so a job
  // in flight is simply dropped with no done pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      sel_q    <= 1'b0;
      data_q   <= '0;
      len_q    <= '0;
      rptTot_q <= '0;
      idx_q    <= '0;
      rptCnt_q <= '0;
      step_q   <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      cmd_q    <= CMD_NONE;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      len_q    <= len_d;
      rptTot_q <= rptTot_d;
      idx_q    <= idx_d;
      rptCnt_q <= rptCnt_d;
      step_q   <= step_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      cmd_q    <= cmd_d;
    end
  end

  // Next-state and output decode. Outputs are registered from the current
  // state, so each one lands one edge after the state that produces it.
  // RGAP runs a small step counter: one zero cycle, then the automatic word
  // gap, then wait for the emitter; cmd_done_sig is only honoured in that
  // last step and in WAIT.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    data_d   = data_q;
    len_d    = len_q;
    rptTot_d = rptTot_q;
    idx_d    = idx_q;
    rptCnt_d = rptCnt_q;
    step_d   = step_q;
    gnt_d    = gnt_q;
    done_d   = 2'b00;
    busy_d   = busy_q;
    cmd_d    = cmd_q;
    arbUpd   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        gnt_d  = 2'b00;
        busy_d = 1'b0;
        cmd_d  = CMD_NONE;
        if (|req_sig) begin
          sel_d   = arbGnt[1];
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        data_d   = sel_q ? msg1_data : msg0_data;
        len_d    = loadLen;
        rptTot_d = (rpt_num == 4'd0) ? 4'd1 : rpt_num;
        idx_d    = '0;
        rptCnt_d = '0;
        step_d   = '0;
        gnt_d    = sel_q ? 2'b10 : 2'b01;
        busy_d   = 1'b1;
        state_d  = (loadLen == 4'd0) ? ST_FINISH : ST_ISSUE;
      end
      ST_ISSUE: begin
        cmd_d   = symToCmd(curSym);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cmd_done_sig) begin
          if (!lastSym) begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_CLEAR;
          end else if (!lastRpt) begin
            idx_d    = '0;
            rptCnt_d = rptCnt_q + 4'd1;
            step_d   = '0;
            state_d  = ST_RGAP;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_CLEAR: begin
        cmd_d   = CMD_NONE;
        state_d = ST_ISSUE;
      end
      ST_RGAP: begin
        case (step_q)
          2'd0: begin
            cmd_d  = CMD_NONE;
            step_d = 2'd1;
          end
          2'd1: begin
            cmd_d  = CMD_WGAP;
            step_d = 2'd2;
          end
          default: begin
            if (cmd_done_sig) begin
              step_d  = '0;
              state_d = ST_CLEAR;
            end
          end
        endcase
      end
      ST_FINISH: begin
        cmd_d   = CMD_NONE;
        done_d  = gnt_q;
        arbUpd  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign gnt_sig       = gnt_q;
  assign done_sig      = done_q;
  assign busy_sig      = busy_q;
  assign func_en_sig   = busy_q;
  assign cmd_start_sig = cmd_q;

endmodule

// File: tb/tb_morse_seq_control.sv
// -----------------------------------------------------------------------------
// tb_morse_seq_control
// Self-checking bench for morse_seq_control: an emitter model answers every
// command after a programmable delay and logs what it saw; a table of jobs
// plus a few hand-written sequences compare the results against hand-computed
// expectations.
// -----------------------------------------------------------------------------
module tb_morse_seq_control;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  req_sig;
  logic [15:0] msg0_data, msg1_data;
  logic [3:0]  msg0_len, msg1_len;
  logic [3:0]  rpt_num;
  logic [1:0]  gnt_sig, done_sig;
  logic        busy_sig, func_en_sig;
  logic [3:0]  cmd_start_sig;
  logic        cmd_done_sig;

  logic        emuDone    = 1'b0;
  logic        manualDone = 1'b0;
  int          emuDelay   = 5;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;

  typedef struct {
    logic [3:0] cmd;
    int         gap;
  } logEnt;

  logEnt cmdLog[$];

  typedef struct {
    logic [1:0]  req;
    logic [15:0] d0;
    logic [3:0]  l0;
    logic [15:0] d1;
    logic [3:0]  l1;
    logic [3:0]  rpt;
    bit          mutate;
    logic [1:0]  expGnt;
    logic [1:0]  expDone;
    int          expNum;
    logic [63:0] expCmds;
  } jobVec;

  jobVec vecs[6];

  int gntCycle, doneCycle;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle <= cycle + 1;

  assign cmd_done_sig = emuDone | manualDone;

  morse_seq_control dut (
    .CLK           (CLK),
    .RST           (RST),
    .req_sig       (req_sig),
    .msg0_data     (msg0_data),
    .msg1_data     (msg1_data),
    .msg0_len      (msg0_len),
    .msg1_len      (msg1_len),
    .rpt_num       (rpt_num),
    .gnt_sig       (gnt_sig),
    .done_sig      (done_sig),
    .busy_sig      (busy_sig),
    .func_en_sig   (func_en_sig),
    .cmd_start_sig (cmd_start_sig),
    .cmd_done_sig  (cmd_done_sig)
  );

  // Emitter model: logs each new command with the number of zero cycles seen
  // since the previous command of the same job, and answers it with a
  // one-cycle done pulse emuDelay cycles later.
  logic [3:0] prevCmd   = 4'b0;
  int         zeroRun   = 0;
  bit         seenCmd   = 1'b0;
  int         countdown = 0;

  always @(negedge CLK) begin
    logEnt e;
    emuDone = 1'b0;
    if (RST) begin
      countdown = 0;
      seenCmd   = 1'b0;
      prevCmd   = 4'b0;
      zeroRun   = 0;
    end else begin
      if (!busy_sig) seenCmd = 1'b0;
      if (cmd_start_sig != 4'b0 && prevCmd == 4'b0) begin
        e.cmd = cmd_start_sig;
        e.gap = seenCmd ? zeroRun : -1;
        cmdLog.push_back(e);
        seenCmd   = 1'b1;
        countdown = emuDelay;
      end
      if (cmd_start_sig == 4'b0) zeroRun = zeroRun + 1;
      else zeroRun = 0;
      if (countdown > 0) begin
        countdown = countdown - 1;
        if (countdown == 0) emuDone = 1'b1;
      end
      prevCmd = cmd_start_sig;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared = compared + 1;
    if (act !== exp) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    compared   = compared + 1;
    mismatched = mismatched + 1;
    $display("[TB] FAIL %s: wait bound expired, expected event not seen", name);
  endtask

  task automatic applyStimulus(input jobVec v);
    @(negedge CLK);
    msg0_data = v.d0;
    msg0_len  = v.l0;
    msg1_data = v.d1;
    msg1_len  = v.l1;
    rpt_num   = v.rpt;
    req_sig   = v.req;
  endtask

  task automatic waitGrant(output logic [1:0] g, output bit ok);
    ok = 1'b0;
    g  = 2'b00;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (gnt_sig != 2'b00) begin
        g  = gnt_sig;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitDone(output logic [1:0] d, output bit ok);
    ok = 1'b0;
    d  = 2'b00;
    for (int c = 0; c < 600; c++) begin
      @(negedge CLK);
      if (done_sig != 2'b00) begin
        d  = done_sig;
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Runs one job end to end and checks grant, done pulse, release and the
  // exact command stream including the single zero cycle between commands.
  task automatic runJob(input jobVec v, input string tag);
    logic [1:0] g, d;
    bit         ok;
    int         startIdx, num;
    startIdx = cmdLog.size();
    applyStimulus(v);
    waitGrant(g, ok);
    req_sig = 2'b00;
    if (!ok) begin
      timeoutFail({tag, "_grant"});
      return;
    end
    gntCycle = cycle;
    checkOutput({tag, "_grant"}, 64'(g), 64'(v.expGnt));
    checkOutput({tag, "_busy"}, 64'({busy_sig, func_en_sig}), 64'(2'b11));
    if (v.mutate) begin
      repeat (3) @(negedge CLK);
      msg0_data = 16'hFFFF;
      msg1_data = 16'hFFFF;
      msg0_len  = 4'd15;
      msg1_len  = 4'd15;
      rpt_num   = 4'd7;
    end
    waitDone(d, ok);
    if (!ok) begin
      timeoutFail({tag, "_done"});
      return;
    end
    doneCycle = cycle;
    checkOutput({tag, "_done"}, 64'(d), 64'(v.expDone));
    checkOutput({tag, "_gnt_at_done"}, 64'(gnt_sig), 64'(v.expGnt));
    @(negedge CLK);
    checkOutput({tag, "_release"}, 64'({done_sig, gnt_sig, busy_sig, func_en_sig, cmd_start_sig}), 64'(0));
    num = cmdLog.size() - startIdx;
    checkOutput({tag, "_num_cmds"}, 64'(num), 64'(v.expNum));
    for (int i = 0; i < num && i < v.expNum; i++) begin
      logic [63:0] ec;
      ec = v.expCmds;
      checkOutput($sformatf("%s_cmd%0d", tag, i), 64'(cmdLog[startIdx + i].cmd), 64'(ec[4*i +: 4]));
      if (i > 0) begin
        checkOutput($sformatf("%s_gap%0d", tag, i), 64'(cmdLog[startIdx + i].gap), 64'(1));
      end
    end
  endtask

  initial begin
    logic [1:0] g, d;
    logic [1:0] altExp[4];
    bit         ok;
    int         idleStart;
    jobVec      v;

    vecs[0] = '{2'b01, 16'h0000, 4'd3,  16'h0000, 4'd0, 4'd1, 1'b0, 2'b01, 2'b01, 3, 64'h111};
    vecs[1] = '{2'b10, 16'h0000, 4'd0,  16'h00E4, 4'd4, 4'd2, 1'b0, 2'b10, 2'b10, 9, 64'h842188421};
    vecs[2] = '{2'b01, 16'hFFFF, 4'd0,  16'h0000, 4'd0, 4'd1, 1'b0, 2'b01, 2'b01, 0, 64'h0};
    vecs[3] = '{2'b01, 16'h1B1B, 4'd12, 16'h0000, 4'd0, 4'd0, 1'b0, 2'b01, 2'b01, 8, 64'h12481248};
    vecs[4] = '{2'b10, 16'h0000, 4'd0,  16'h0001, 4'd1, 4'd3, 1'b0, 2'b10, 2'b10, 5, 64'h28282};
    vecs[5] = '{2'b01, 16'h00E4, 4'd4,  16'h0000, 4'd0, 4'd1, 1'b1, 2'b01, 2'b01, 4, 64'h8421};
    altExp  = '{2'b01, 2'b10, 2'b01, 2'b10};

    RST       = 1'b1;
    req_sig   = 2'b00;
    msg0_data = 16'h0;
    msg1_data = 16'h0;
    msg0_len  = 4'd0;
    msg1_len  = 4'd0;
    rpt_num   = 4'd0;

    // Reset state.
    repeat (3) @(negedge CLK);
    checkOutput("reset_outputs", 64'({gnt_sig, done_sig, busy_sig, func_en_sig, cmd_start_sig}), 64'(0));
    RST = 1'b0;

    // Latency of the first grant and first command.
    @(negedge CLK);
    msg0_data = 16'h0001;
    msg0_len  = 4'd1;
    rpt_num   = 4'd1;
    req_sig   = 2'b01;
    @(negedge CLK);
    checkOutput("lat_gnt_T", 64'(gnt_sig), 64'(0));
    @(negedge CLK);
    checkOutput("lat_gnt_T1", 64'({gnt_sig, busy_sig, func_en_sig, cmd_start_sig}), 64'({2'b01, 1'b1, 1'b1, 4'b0000}));
    req_sig = 2'b00;
    @(negedge CLK);
    checkOutput("lat_cmd_T2", 64'(cmd_start_sig), 64'(4'b0010));
    waitDone(d, ok);
    if (!ok) timeoutFail("lat_done");
    else checkOutput("lat_done", 64'(d), 64'(2'b01));
    repeat (3) @(negedge CLK);

    // Table of single-requester jobs.
    for (int i = 0; i < 5; i++) begin
      runJob(vecs[i], $sformatf("job%0d", i));
      if (vecs[i].expNum == 0) begin
        checkOutput("len0_done_latency", 64'(doneCycle - gntCycle), 64'(1));
      end
      repeat (2) @(negedge CLK);
    end

    // Both requesters held: grants alternate, starting with requester 0.
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST       = 1'b0;
    msg0_data = 16'h0000;
    msg1_data = 16'h0001;
    msg0_len  = 4'd1;
    msg1_len  = 4'd1;
    rpt_num   = 4'd1;
    req_sig   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      waitGrant(g, ok);
      if (!ok) begin
        timeoutFail($sformatf("alt_grant%0d", k));
      end else begin
        checkOutput($sformatf("alt_grant%0d", k), 64'(g), 64'(altExp[k]));
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
          @(negedge CLK);
          if (gnt_sig == 2'b00) begin
            ok = 1'b1;
            break;
          end
        end
        if (!ok) timeoutFail($sformatf("alt_release%0d", k));
      end
    end
    req_sig = 2'b00;
    repeat (4) @(negedge CLK);

    // Reset while waiting on the emitter.
    emuDelay = 30;
    v = vecs[0];
    applyStimulus(v);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (cmd_start_sig != 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
    req_sig = 2'b00;
    if (!ok) timeoutFail("rst_reach_wait");
    repeat (2) @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("rst_midjob_outputs", 64'({gnt_sig, done_sig, busy_sig, func_en_sig, cmd_start_sig}), 64'(0));
    repeat (3) begin
      @(negedge CLK);
      checkOutput("rst_no_done", 64'(done_sig), 64'(0));
    end
    RST      = 1'b0;
    emuDelay = 5;
    runJob(vecs[0], "after_rst");
    repeat (2) @(negedge CLK);

    // cmd_done_sig in IDLE is ignored, then a job whose inputs change mid-run.
    idleStart = cmdLog.size();
    @(negedge CLK);
    manualDone = 1'b1;
    @(negedge CLK);
    manualDone = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      checkOutput("idle_done_ignored", 64'({busy_sig, cmd_start_sig}), 64'(0));
    end
    checkOutput("idle_no_cmd_logged", 64'(cmdLog.size() - idleStart), 64'(0));
    runJob(vecs[5], "latched");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard stop so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation time limit reached");
    $fatal(1, "[TB] global timeout");
  end

endmodule
